// File: rtl/tacho_pkg.sv
// Shared types and helpers for the tachometer window sequencer.
package tacho_pkg;

  localparam int DEF_WINDOW_CYCLES = 100_000_000;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic {G_IDLE, G_GATE} gate_state_t;
  typedef enum logic {A_OK,   A_ON}   alarm_state_t;

  // Saturating subtract (floors at zero); callers keep widths <= 32.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/tacho_window_sequencer_if.sv
// Control/result bus between the tachometer sequencer and the top level.
interface tacho_window_sequencer_if #(parameter int CNT_W = 16);
  logic             enable;
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] hyst;
  logic             tick;
  logic             done;
  logic [CNT_W-1:0] count_out;
  logic             overflow;
  logic             led;
  logic             buzzer;

  modport master (output enable, threshold, hyst,
                  input  tick, done, count_out, overflow, led, buzzer);
  modport slave  (input  enable, threshold, hyst,
                  output tick, done, count_out, overflow, led, buzzer);
endinterface

// File: rtl/tacho_pulse_conditioner.sv
// Hall input conditioning: 2-FF sync, level debounce, 1-cycle rising-edge event.
module tacho_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic evt
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync;
  logic            level;
  logic [DB_W-1:0] db_cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // evt fires in the same edge that accepts a low->high change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      level  <= 1'b0;
      db_cnt <= '0;
      evt    <= 1'b0;
    end else begin
      sync <= {sync[0], pulse_in};
      evt  <= 1'b0;
      if (sync[1] == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level  <= sync[1];
        db_cnt <= '0;
        evt    <= sync[1];
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end
endmodule

// File: rtl/tacho_window_sequencer.sv
// Gate-window pulse counter with confirmed, hysteretic over-speed alarm.
module tacho_window_sequencer
  import tacho_pkg::*;
#(
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CONFIRM_WINDOWS = 2,
  parameter int BUZZ_DIV        = 50_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pulse_in,
  tacho_window_sequencer_if.slave  bus
);
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int CONF_W = $clog2(CONFIRM_WINDOWS + 1);
  localparam int BZ_W   = $clog2(BUZZ_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             evt;
  gate_state_t      gstate;
  alarm_state_t     astate;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] pcnt, thr_l, hyst_l, count_r;
  logic             povf, tick_r, done_r, ovf_r, led_r, buzz_r;
  logic [CONF_W-1:0] conf;
  logic [BZ_W-1:0]  bz_cnt;

  tacho_pulse_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .evt      (evt)
  );

  logic             last_cyc, gate_run, hi, lo;
  logic [CNT_W-1:0] pcnt_nxt, clr_lvl;
  logic             povf_nxt;

  assign gate_run = (gstate == G_GATE) && bus.enable;
  assign last_cyc = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  assign pcnt_nxt = (evt && (pcnt != CNT_MAX)) ? pcnt + CNT_W'(1) : pcnt;
  assign povf_nxt = povf | (evt & (pcnt == CNT_MAX));
  assign clr_lvl  = CNT_W'(sat_sub(32'(thr_l), 32'(hyst_l)));
  assign hi       = ovf_r | (count_r >= thr_l);
  assign lo       = ~ovf_r & (count_r < clr_lvl);

  // Gate FSM: back-to-back windows, pulse counting, result publish on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gstate  <= G_IDLE;
      win_cnt <= '0;
      pcnt    <= '0;
      povf    <= 1'b0;
      thr_l   <= '0;
      hyst_l  <= '0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      case (gstate)
        G_IDLE: if (bus.enable) begin
          gstate  <= G_GATE;
          win_cnt <= '0;
          pcnt    <= '0;
          povf    <= 1'b0;
          tick_r  <= 1'b1;
        end
        G_GATE: if (!bus.enable) begin
          // Abort: the partial window is dropped, count_out keeps its last value.
          gstate  <= G_IDLE;
          win_cnt <= '0;
          pcnt    <= '0;
          povf    <= 1'b0;
        end else begin
          if (win_cnt == '0) begin
            thr_l  <= bus.threshold;
            hyst_l <= bus.hyst;
          end
          if (last_cyc) begin
            // An evt in the following (done) cycle counts into the new window.
            win_cnt <= '0;
            tick_r  <= 1'b1;
            done_r  <= 1'b1;
            count_r <= pcnt_nxt;
            ovf_r   <= povf_nxt;
            pcnt    <= '0;
            povf    <= 1'b0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            pcnt    <= pcnt_nxt;
            povf    <= povf_nxt;
          end
        end
        default: gstate <= G_IDLE;
      endcase
    end
  end

  // Alarm FSM: N consecutive hi windows to raise, N consecutive lo windows to clear; buzzer tone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate <= A_OK;
      conf   <= '0;
      led_r  <= 1'b0;
      buzz_r <= 1'b0;
      bz_cnt <= '0;
    end else if (!gate_run) begin
      astate <= A_OK;
      conf   <= '0;
      led_r  <= 1'b0;
      buzz_r <= 1'b0;
      bz_cnt <= '0;
    end else begin
      if (astate == A_ON) begin
        if (bz_cnt == BZ_W'(BUZZ_DIV - 1)) begin
          bz_cnt <= '0;
          buzz_r <= ~buzz_r;
        end else begin
          bz_cnt <= bz_cnt + BZ_W'(1);
        end
      end
      if (done_r) begin
        case (astate)
          A_OK: if (!hi) conf <= '0;
                else if (conf == CONF_W'(CONFIRM_WINDOWS - 1)) begin
                  astate <= A_ON;
                  conf   <= '0;
                  led_r  <= 1'b1;
                  buzz_r <= 1'b1;
                  bz_cnt <= '0;
                end else conf <= conf + CONF_W'(1);
          A_ON: if (!lo) conf <= '0;
                else if (conf == CONF_W'(CONFIRM_WINDOWS - 1)) begin
                  astate <= A_OK;
                  conf   <= '0;
                  led_r  <= 1'b0;
                  buzz_r <= 1'b0;
                  bz_cnt <= '0;
                end else conf <= conf + CONF_W'(1);
          default: astate <= A_OK;
        endcase
      end
    end
  end

  assign bus.tick      = tick_r;
  assign bus.done      = done_r;
  assign bus.count_out = count_r;
  assign bus.overflow  = ovf_r;
  assign bus.led       = led_r;
  assign bus.buzzer    = buzz_r;
endmodule

// File: tb/tb_tacho_window_sequencer.sv
// Randomized window-level bench for tacho_window_sequencer (CNT_W=16 and CNT_W=4 copies).
module tb_tacho_window_sequencer;
  localparam int W = 100, D = 2, C = 2, BZ = 5, THR = 3, HYS = 1;
  localparam int L = 2 + D;            // pin change to evt, in cycles
  localparam int K_NORM = 0, K_GLITCH = 1, K_EDGE = 2, K_DIS = 3, K_RST = 4;

  logic clk = 1'b0, rst_n = 1'b0, pulse_in = 1'b0, enable = 1'b0;
  always #5 clk = ~clk;

  tacho_window_sequencer_if #(.CNT_W(16)) bus_a ();
  tacho_window_sequencer_if #(.CNT_W(4))  bus_b ();
  assign bus_a.enable = enable;
  assign bus_b.enable = enable;
  assign bus_a.threshold = 16'(THR);
  assign bus_a.hyst      = 16'(HYS);
  assign bus_b.threshold = 4'(THR);
  assign bus_b.hyst      = 4'(HYS);

  tacho_window_sequencer #(.WINDOW_CYCLES(W), .CNT_W(16), .DEBOUNCE_CYCLES(D),
    .CONFIRM_WINDOWS(C), .BUZZ_DIV(BZ)) dut_a (.clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .bus(bus_a));
  tacho_window_sequencer #(.WINDOW_CYCLES(W), .CNT_W(4), .DEBOUNCE_CYCLES(D),
    .CONFIRM_WINDOWS(C), .BUZZ_DIV(BZ)) dut_b (.clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .bus(bus_b));

  int n_tests = 0, n_fail = 0;
  int m_alarm = 0, m_conf = 0, m_j = 0;                 // alarm reference
  int last_ca = 0, last_cb = 0, last_oa = 0, last_ob = 0; // published results
  int prev_valid = 0, prev_cnt = 0, carry = 0, win_idx = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic string tg(input int c, input string s);
    return $sformatf("w%0d.c%0d.%s", win_idx, c, s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int c, input int et, input int ed);
    int eb;
    eb = (m_alarm != 0 && ((m_j / BZ) % 2 == 0)) ? 1 : 0;
    if (m_alarm != 0) m_j++;
    chk(tg(c, "tick_a"),  int'(bus_a.tick),      et);
    chk(tg(c, "tick_b"),  int'(bus_b.tick),      et);
    chk(tg(c, "done_a"),  int'(bus_a.done),      ed);
    chk(tg(c, "done_b"),  int'(bus_b.done),      ed);
    chk(tg(c, "count_a"), int'(bus_a.count_out), last_ca);
    chk(tg(c, "count_b"), int'(bus_b.count_out), last_cb);
    chk(tg(c, "ovf_a"),   int'(bus_a.overflow),  last_oa);
    chk(tg(c, "ovf_b"),   int'(bus_b.overflow),  last_ob);
    chk(tg(c, "led_a"),   int'(bus_a.led),       m_alarm);
    chk(tg(c, "led_b"),   int'(bus_b.led),       m_alarm);
    chk(tg(c, "buzz_a"),  int'(bus_a.buzzer),    eb);
    chk(tg(c, "buzz_b"),  int'(bus_b.buzzer),    eb);
  endtask

  // Alarm rules applied to one completed window of n edges (saturation in the 4-bit copy
  // only happens for n > 15, which is hi for both copies alike).
  task automatic alarm_update(input int n);
    int clr;
    clr = (THR > HYS) ? THR - HYS : 0;
    if (m_alarm == 0) begin
      if (n >= THR) begin
        m_conf++;
        if (m_conf == C) begin m_alarm = 1; m_conf = 0; m_j = 0; end
      end else m_conf = 0;
    end else begin
      if (n < clr) begin
        m_conf++;
        if (m_conf == C) begin m_alarm = 0; m_conf = 0; end
      end else m_conf = 0;
    end
  endtask

  task automatic model_reset();
    m_alarm = 0; m_conf = 0; m_j = 0; prev_valid = 0; carry = 0;
  endtask

  // One gate window, entered and left at window cycle 0 (#1 after the tick edge).
  task automatic run_window(input int kind, input int n, input int hl);
    logic sched [W];
    int pos, h, l, own, ncarry;
    for (int i = 0; i < W; i++) sched[i] = 1'b0;
    own = carry; ncarry = 0;
    if (kind == K_GLITCH) begin
      for (int i = 0; i < n; i++) sched[4 + 4 * i] = 1'b1;
    end else if (kind == K_EDGE) begin
      for (int i = W - L; i < W; i++) sched[i] = 1'b1;
      ncarry = 1;
    end else begin
      pos = 4 + ((hl != 0) ? 0 : int'($urandom_range(0, 5)));
      for (int i = 0; i < n; i++) begin
        h = (hl != 0) ? hl : int'($urandom_range(2, 4));
        l = (hl != 0) ? hl : int'($urandom_range(2, 4));
        for (int k = 0; k < h; k++) if (pos + k < W) sched[pos + k] = 1'b1;
        if (pos + L < W) own++; else ncarry++;
        pos += h + l;
      end
    end
    for (int c = 0; c < W; c++) begin
      if (c == 0 && prev_valid != 0) begin
        last_ca = prev_cnt;
        last_cb = (prev_cnt > 15) ? 15 : prev_cnt;
        last_oa = 0;
        last_ob = (prev_cnt > 15) ? 1 : 0;
      end
      check_outs(c, (c == 0) ? 1 : 0, (c == 0 && prev_valid != 0) ? 1 : 0);
      if (c == 0 && prev_valid != 0) alarm_update(prev_cnt);
      if (kind == K_DIS && c == 50) begin
        enable = 1'b0; pulse_in = 1'b0;
        step();
        model_reset();
        for (int i = 0; i < 20; i++) begin check_outs(51 + i, 0, 0); step(); end
        enable = 1'b1;
        step();
        win_idx++;
        return;
      end
      if (kind == K_RST && c == 30) begin
        pulse_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        last_ca = 0; last_cb = 0; last_oa = 0; last_ob = 0;
        check_outs(c, 0, 0);
        step();
        check_outs(c + 1, 0, 0);
        rst_n = 1'b1;
        step();
        win_idx++;
        return;
      end
      pulse_in = sched[c];
      step();
    end
    prev_cnt = own; carry = ncarry; prev_valid = 1;
    win_idx++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0;
    step(); step();
    check_outs(-1, 0, 0);
    rst_n = 1'b1;
    step(); step();
    check_outs(-2, 0, 0);
    enable = 1'b1;
    step();
    run_window(K_NORM, 1, 4);  run_window(K_NORM, 1, 4);
    run_window(K_NORM, 3, 4);  run_window(K_NORM, 3, 4);
    run_window(K_NORM, 2, 0);  run_window(K_NORM, 1, 0);  run_window(K_NORM, 1, 0);
    run_window(K_GLITCH, 5, 0);
    run_window(K_NORM, 20, 2); run_window(K_NORM, 2, 0);
    run_window(K_EDGE, 0, 0);  run_window(K_NORM, 0, 0);
    for (int i = 0; i < 16; i++) run_window(K_NORM, int'($urandom_range(0, 8)), 0);
    run_window(K_NORM, 5, 0);  run_window(K_NORM, 5, 0);
    run_window(K_DIS, 2, 0);
    run_window(K_NORM, 4, 0);  run_window(K_NORM, 4, 0);  run_window(K_NORM, 3, 0);
    run_window(K_RST, 2, 0);
    run_window(K_NORM, 3, 0);  run_window(K_NORM, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
